riscv_alu_issue: RTL
====================

Name: riscv_alu_issue

Overview:
- Driving and consuming end of the ALU interface.
- Decodes RV32I integer instructions (OP, OP-IMM, LUI, AUIPC) into ALU op-code and operand pair, presents them to the combinational ALU from a registered issue stage, and captures the ALU result into a registered writeback stage.
- Two-stage valid/ready pipeline between the operand-read stage and register-file writeback.

Parameters:
SUPPORT_LUI_AUIPC, 1, 1 = decode LUI/AUIPC; 0 = both flagged illegal

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous reset, active-high
flush_i  input  1  discard all in-flight instructions
in_valid_i  input  1  instruction + operands valid
in_ready_o  output  1  block accepts input this cycle
in_opcode_i  input  32  instruction word
in_pc_i  input  32  instruction PC
in_ra_value_i  input  32  rs1 value
in_rb_value_i  input  32  rs2 value
alu_op_o  output  4  ALU op-code (riscv_defs ALU_* encodings)
alu_a_o  output  32  ALU operand A
alu_b_o  output  32  ALU operand B
alu_p_i  input  32  ALU result (combinational from alu_op_o/a/b)
wb_valid_o  output  1  writeback entry valid
wb_ready_i  input  1  writeback consumer accepts
wb_rd_o  output  5  destination register
wb_we_o  output  1  register write enable
wb_value_o  output  32  result
wb_pc_o  output  32  PC of retiring instruction
wb_illegal_o  output  1  instruction not decodable by this block

Behaviour:
- Reset (rst_i high at clock edge): issue_valid=0, wb_valid_o=0. All other registered outputs = 0; alu_op_o = ALU_NONE.
- Issue stage register holds op, a, b, rd, we, pc, illegal. alu_op_o/alu_a_o/alu_b_o come directly from it, with no combinational path from in_*.
- Handshakes:
  - wb_adv = !wb_valid_o || wb_ready_i
  - in_ready_o = !issue_valid || wb_adv
  - Input transfer on in_valid_i && in_ready_o.
  - Issue-to-wb transfer on issue_valid && wb_adv. wb captures alu_p_i, rd, we, pc, illegal.
- Latency and throughput:
  - Instruction accepted at edge N appears on wb_valid_o after edge N+1.
  - Full throughput of 1 instruction/cycle when wb_ready_i=1.
- Backpressure: when wb_valid_o && !wb_ready_i, both stages hold and the pipeline holds at most 2 instructions. All wb_* outputs stay stable while wb_valid_o && !wb_ready_i.
- Flush: flush_i clears issue_valid and wb_valid_o at the next edge. An input handshake in the same cycle is dropped. flush_i has priority over any transfer; rst_i has priority over flush_i.
- Decode, OP (opcode 0110011): a=rs1, b=rs2.
  - funct3 000 → ADD when funct7=0000000, SUB when funct7=0100000
  - 001 → SHIFTL, 010 → LESS_THAN_SIGNED, 011 → LESS_THAN, 100 → XOR
  - 101 → SHIFTR when funct7=0000000, SHIFTR_ARITH when funct7=0100000
  - 110 → OR, 111 → AND
  - Any other funct7 → illegal.
- Decode, OP-IMM (0010011): a=rs1, b=sign-extended instr[31:20].
  - SLLI/SRLI/SRAI use b={27'b0,instr[24:20]}.
  - SLLI requires funct7=0000000.
  - SRLI/SRAI require funct7 0000000/0100000; otherwise illegal.
  - No subtract-immediate: funct3 000 is always ADD.
- Decode, LUI (0110111): ADD, a=0, b={instr[31:12],12'b0}.
- Decode, AUIPC (0010111): ADD, a=in_pc_i, b=U-immediate.
- Illegal instructions (any other opcode, bad funct7, LUI/AUIPC with SUPPORT_LUI_AUIPC=0): op=ALU_NONE, we=0, illegal=1. Still flows through the pipeline in order.
- Write enable: we=1 only for legal instructions with rd≠0. The result is still computed for rd=0.
- Arithmetic is 32-bit wrap-around. SUB and compares are evaluated by the ALU. This block performs no arithmetic except immediate extension.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), ra=5, rb=7, wb_ready_i=1 → alu_op_o=ADD one cycle after accept; next cycle wb_valid_o=1, wb_rd_o=3, wb_we_o=1, wb_value_o=12.
- SUB (0x402081B3), ra=5, rb=7 → wb_value_o=0xFFFFFFFE. SRAI x5,x1,4 (0x4040D293), ra=0x80000000 → alu_b_o=4, wb_value_o=0xF8000000, wb_rd_o=5.
- LUI x1,0x12345 (0x123450B7) → 0x12345000. AUIPC x1,1 (0x00001097), pc=0x100 → 0x1100. Repeat both with SUPPORT_LUI_AUIPC=0 → wb_illegal_o=1, wb_we_o=0.
- ADDI x0,x0,1 (0x00100013) → wb_we_o=0, wb_value_o=1. Word 0x00000000 → wb_illegal_o=1, wb_we_o=0. SLTI x2,x1,-1 (0xFFF0A113), ra=0 → 0.
- Stream 4 ADDI x1,x1,k (k=1..4) with wb_ready_i=0 for 5 cycles → in_ready_o drops after 2 accepts, wb_* stable. On release, results emerge in order with no loss or duplication.
- Assert flush_i with 2 in flight plus a concurrent input → next cycle wb_valid_o=0, no transfers. Assert rst_i mid-stream → all valids 0 next cycle.

Source files
------------

// File: rtl/riscv_alu_issue.sv
// ---------------------------------------------------------------------------
// riscv_alu_issue
//   Decodes RV32I integer instructions (OP, OP-IMM, LUI, AUIPC) into an ALU
//   op-code plus operand pair. The decoded operation is presented to an
//   external combinational ALU from a registered issue stage. The ALU result
//   is captured into a registered writeback stage. The two stages form a
//   valid/ready pipeline: 1 instruction/cycle when the consumer is ready,
//   and at most 2 instructions held under backpressure.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   flush_i              discard every in-flight instruction
//   in_valid_i/ready_o   input handshake (instruction, pc, rs1/rs2 values)
//   in_opcode_i          32-bit instruction word
//   in_pc_i              instruction PC
//   in_ra_value_i        rs1 value
//   in_rb_value_i        rs2 value
//   alu_op_o/a_o/b_o     registered ALU request from the issue stage
//   alu_p_i              combinational ALU result for alu_op_o/a_o/b_o
//   wb_valid_o/ready_i   writeback handshake
//   wb_rd_o, wb_we_o     destination register and its write enable
//   wb_value_o, wb_pc_o  result value and PC of the retiring instruction
//   wb_illegal_o         instruction was not decodable by this block
// ---------------------------------------------------------------------------
module riscv_alu_issue #(
    parameter bit SUPPORT_LUI_AUIPC = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,

    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_opcode_i,
    input  logic [31:0] in_pc_i,
    input  logic [31:0] in_ra_value_i,
    input  logic [31:0] in_rb_value_i,

    output logic [3:0]  alu_op_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    input  logic [31:0] alu_p_i,

    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [4:0]  wb_rd_o,
    output logic        wb_we_o,
    output logic [31:0] wb_value_o,
    output logic [31:0] wb_pc_o,
    output logic        wb_illegal_o
);

    // ALU op-code encodings shared with the ALU (riscv_defs ALU_*).
    typedef enum logic [3:0] {
        ALU_NONE             = 4'b0000,
        ALU_SHIFTL           = 4'b0001,
        ALU_SHIFTR           = 4'b0010,
        ALU_SHIFTR_ARITH     = 4'b0011,
        ALU_ADD              = 4'b0100,
        ALU_SUB              = 4'b0110,
        ALU_AND              = 4'b0111,
        ALU_OR               = 4'b1000,
        ALU_XOR              = 4'b1001,
        ALU_LESS_THAN        = 4'b1010,
        ALU_LESS_THAN_SIGNED = 4'b1011
    } alu_op_t;

    // Major opcodes handled by this block.
    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111
    } opcode_t;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // -----------------------------------------------------------------------
    // Instruction fields
    // -----------------------------------------------------------------------
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_field;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] imm_shamt;

    assign funct3    = in_opcode_i[14:12];
    assign funct7    = in_opcode_i[31:25];
    assign rd_field  = in_opcode_i[11:7];
    assign imm_i     = {{20{in_opcode_i[31]}}, in_opcode_i[31:20]};
    assign imm_u     = {in_opcode_i[31:12], 12'b0};
    assign imm_shamt = {27'b0, in_opcode_i[24:20]};

    // -----------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------
    alu_op_t     dec_op;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic        dec_illegal;
    logic        dec_we;

    always_comb begin
        dec_op      = ALU_NONE;
        dec_a       = '0;
        dec_b       = '0;
        dec_illegal = 1'b0;

        case (opcode_t'(in_opcode_i[6:0]))
            OPC_OP: begin
                dec_a = in_ra_value_i;
                dec_b = in_rb_value_i;
                if (funct7 == FUNCT7_BASE) begin
                    case (funct3)
                        3'b000:  dec_op = ALU_ADD;
                        3'b001:  dec_op = ALU_SHIFTL;
                        3'b010:  dec_op = ALU_LESS_THAN_SIGNED;
                        3'b011:  dec_op = ALU_LESS_THAN;
                        3'b100:  dec_op = ALU_XOR;
                        3'b101:  dec_op = ALU_SHIFTR;
                        3'b110:  dec_op = ALU_OR;
                        default: dec_op = ALU_AND;
                    endcase
                end else if (funct7 == FUNCT7_ALT && funct3 == 3'b000) begin
                    dec_op = ALU_SUB;
                end else if (funct7 == FUNCT7_ALT && funct3 == 3'b101) begin
                    dec_op = ALU_SHIFTR_ARITH;
                end else begin
                    dec_illegal = 1'b1;
                end
            end

            OPC_OP_IMM: begin
                dec_a = in_ra_value_i;
                dec_b = imm_i;
                case (funct3)
                    3'b000:  dec_op = ALU_ADD;
                    3'b010:  dec_op = ALU_LESS_THAN_SIGNED;
                    3'b011:  dec_op = ALU_LESS_THAN;
                    3'b100:  dec_op = ALU_XOR;
                    3'b110:  dec_op = ALU_OR;
                    3'b111:  dec_op = ALU_AND;
                    3'b001: begin
                        dec_b = imm_shamt;
                        if (funct7 == FUNCT7_BASE)
                            dec_op = ALU_SHIFTL;
                        else
                            dec_illegal = 1'b1;
                    end
                    default: begin
                        // 3'b101: funct7 picks logical vs arithmetic shift.
                        dec_b = imm_shamt;
                        if (funct7 == FUNCT7_BASE)
                            dec_op = ALU_SHIFTR;
                        else if (funct7 == FUNCT7_ALT)
                            dec_op = ALU_SHIFTR_ARITH;
                        else
                            dec_illegal = 1'b1;
                    end
                endcase
            end

            OPC_LUI: begin
                if (SUPPORT_LUI_AUIPC) begin
                    dec_op = ALU_ADD;
                    dec_a  = '0;
                    dec_b  = imm_u;
                end else begin
                    dec_illegal = 1'b1;
                end
            end

            OPC_AUIPC: begin
                if (SUPPORT_LUI_AUIPC) begin
                    dec_op = ALU_ADD;
                    dec_a  = in_pc_i;
                    dec_b  = imm_u;
                end else begin
                    dec_illegal = 1'b1;
                end
            end

            default: dec_illegal = 1'b1;
        endcase

        // Illegal instructions always present ALU_NONE to the ALU.
        if (dec_illegal)
            dec_op = ALU_NONE;
    end

    // Results for rd=x0 are still computed, just never written.
    assign dec_we = !dec_illegal && (rd_field != 5'd0);

    // -----------------------------------------------------------------------
    // Handshakes
    // -----------------------------------------------------------------------
    logic    issue_valid;
    alu_op_t issue_op;
    logic [31:0] issue_a;
    logic [31:0] issue_b;
    logic [4:0]  issue_rd;
    logic        issue_we;
    logic [31:0] issue_pc;
    logic        issue_illegal;

    logic wb_adv;
    logic in_fire;

    assign wb_adv     = !wb_valid_o || wb_ready_i;
    assign in_ready_o = !issue_valid || wb_adv;
    assign in_fire    = in_valid_i && in_ready_o;

    // -----------------------------------------------------------------------
    // Issue and writeback stages
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            issue_valid   <= 1'b0;
            issue_op      <= ALU_NONE;
            issue_a       <= '0;
            issue_b       <= '0;
            issue_rd      <= '0;
            issue_we      <= 1'b0;
            issue_pc      <= '0;
            issue_illegal <= 1'b0;
            wb_valid_o    <= 1'b0;
            wb_rd_o       <= '0;
            wb_we_o       <= 1'b0;
            wb_value_o    <= '0;
            wb_pc_o       <= '0;
            wb_illegal_o  <= 1'b0;
        end else if (flush_i) begin
            // A handshake in the same cycle is dropped along with the rest.
            issue_valid <= 1'b0;
            wb_valid_o  <= 1'b0;
        end else begin
            if (in_fire) begin
                issue_valid   <= 1'b1;
                issue_op      <= dec_op;
                issue_a       <= dec_a;
                issue_b       <= dec_b;
                issue_rd      <= rd_field;
                issue_we      <= dec_we;
                issue_pc      <= in_pc_i;
                issue_illegal <= dec_illegal;
            end else if (wb_adv) begin
                issue_valid <= 1'b0;
            end

            // Data fields only load with a real instruction, so a held
            // writeback entry never changes under backpressure.
            if (wb_adv) begin
                wb_valid_o <= issue_valid;
                if (issue_valid) begin
                    wb_rd_o      <= issue_rd;
                    wb_we_o      <= issue_we;
                    wb_value_o   <= alu_p_i;
                    wb_pc_o      <= issue_pc;
                    wb_illegal_o <= issue_illegal;
                end
            end
        end
    end

    assign alu_op_o = issue_op;
    assign alu_a_o  = issue_a;
    assign alu_b_o  = issue_b;

endmodule
